// File: rtl/sr_latch_bank.sv
// sr_latch_bank: WIDTH independent clocked set/reset channels.
// Each channel has a stability filter on its {s,r} pair, a shared runtime
// conflict mode, one-cycle rose/fell pulses and a shared sticky conflict flag.
// Everything is synchronous to clk except the asynchronous reset.
module sr_latch_bank #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned FILTER = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       mode,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic [WIDTH-1:0] rose,
    output logic [WIDTH-1:0] fell,
    output logic             err
);

    localparam int unsigned   SW        = $clog2(FILTER + 1);
    localparam logic [SW-1:0] STAB_FULL = SW'(FILTER);

    localparam logic [1:0] MODE_RST_DOM = 2'b00;
    localparam logic [1:0] MODE_SET_DOM = 2'b01;
    localparam logic [1:0] MODE_HOLD    = 2'b10;
    localparam logic [1:0] MODE_TOGGLE  = 2'b11;

    // Per-channel sampled pair and stability count
    logic [1:0]       in_q      [WIDTH];
    logic [SW-1:0]    stab      [WIDTH];
    logic [SW-1:0]    stab_next [WIDTH];
    // Fresh event qualified this cycle, and its registered copy that acts next edge
    logic [WIDTH-1:0] fresh;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] q_next;
    logic             err_hit;

    // Stability filter: restart on pair change, saturate at FILTER, fire once per held pair
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            stab_next[i] = STAB_FULL;
            fresh[i]     = 1'b0;
            if ({s[i], r[i]} != in_q[i]) begin
                stab_next[i] = SW'(1);
            end else if (stab[i] < STAB_FULL) begin
                stab_next[i] = stab[i] + SW'(1);
            end
            fresh[i] = (stab_next[i] == STAB_FULL) &&
                       (({s[i], r[i]} != in_q[i]) || (stab[i] < STAB_FULL));
        end
    end

    // Action decode for channels whose fresh event was registered last edge;
    // in_q still holds the qualifying pair because a fresh pair was just re-sampled
    always_comb begin
        q_next  = q;
        err_hit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (evt[i]) begin
                case (in_q[i])
                    2'b10: q_next[i] = 1'b1;
                    2'b01: q_next[i] = 1'b0;
                    2'b11: begin
                        case (mode)
                            MODE_RST_DOM: q_next[i] = 1'b0;
                            MODE_SET_DOM: q_next[i] = 1'b1;
                            MODE_HOLD:    q_next[i] = q[i];
                            MODE_TOGGLE:  q_next[i] = ~q[i];
                            default:      q_next[i] = q[i];
                        endcase
                        if (mode != MODE_TOGGLE) begin
                            err_hit = 1'b1;
                        end
                    end
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    // State, pulse and sticky flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                in_q[i] <= 2'b00;
                stab[i] <= STAB_FULL;
            end
            evt  <= '0;
            q    <= '0;
            rose <= '0;
            fell <= '0;
            err  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                in_q[i] <= {s[i], r[i]};
                stab[i] <= stab_next[i];
            end
            evt  <= fresh;
            q    <= q_next;
            rose <= q_next & ~q;
            fell <= q & ~q_next;
            err  <= err_hit | (err & ~clr_err);
        end
    end

    assign q_not = ~q;

endmodule
